pcm_frame_sched: RTL and testbench

Per-frame scheduler that shares one PCM output stream between up to 16 CIC decimator channels. On every rising edge of the PCM frame clock it snapshots all channel samples. It then drains the enabled channels in ascending index order over a valid/ready stream to the downstream consumer (DOA estimator, sample FIFO). It sits between the CIC bank and any single-port sample consumer, and flags frames that arrive before the previous one has drained.

---
 rtl/pcm_frame_sched.sv | 125 ++++++++++++
 tb/tb_pcm_frame_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_sched.sv
// Snapshots all channel samples on each clk_pcm rise and drains enabled channels, lowest index first.
// First beat registered 3 clk after the clk_pcm rise; beats hold under out_ready low; late frames dropped and flagged.
module pcm_frame_sched #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_pcm,
  input  logic [CHANNELS*WIDTH-1:0] pcm_in,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic                      overrun_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [3:0]                out_chan,
  output logic                      out_last,
  output logic                      overrun,
  output logic [7:0]                frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic                      sync1, sync2, sync3;
  logic                      primed, armed;
  logic                      strobe, fire, final_fire, accept;
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic [CHANNELS-1:0]       mask_q;
  logic                      first_any, first_last;
  logic [3:0]                first_idx;
  logic [WIDTH-1:0]          first_data;
  logic                      next_any, next_last;
  logic [3:0]                next_idx;
  logic [WIDTH-1:0]          next_data;

  // armed stays low until clk_pcm has been seen low after reset, so a level that is
  // already high at reset release is not mistaken for a rising edge.
  assign strobe     = sync2 & ~sync3 & armed;
  assign fire       = out_valid & out_ready;
  assign final_fire = fire & out_last;
  assign accept     = strobe & ((state == IDLE) | final_fire);

  always_comb begin
    first_any  = 1'b0;
    first_last = 1'b1;
    first_idx  = '0;
    first_data = '0;
    next_any   = 1'b0;
    next_last  = 1'b1;
    next_idx   = out_chan;
    next_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_mask[i]) begin
        if (!first_any) begin
          first_any  = 1'b1;
          first_idx  = 4'(i);
          first_data = pcm_in[i*WIDTH +: WIDTH];
        end else begin
          first_last = 1'b0;
        end
      end
      if (mask_q[i] && (i > int'(out_chan))) begin
        if (!next_any) begin
          next_any  = 1'b1;
          next_idx  = 4'(i);
          next_data = shadow[i*WIDTH +: WIDTH];
        end else begin
          next_last = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      primed    <= 1'b0;
      armed     <= 1'b0;
      shadow    <= '0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sync1  <= clk_pcm;
      sync2  <= sync1;
      sync3  <= sync2;
      primed <= 1'b1;
      if (primed && !sync1) armed <= 1'b1;

      if (strobe) frame_cnt <= frame_cnt + 8'd1;
      if (overrun_clr) overrun <= 1'b0;
      if (strobe && !accept) overrun <= 1'b1;

      if (accept) begin
        shadow    <= pcm_in;
        mask_q    <= chan_mask;
        out_valid <= first_any;
        state     <= first_any ? SEND : IDLE;
        if (first_any) begin
          out_chan <= first_idx;
          out_data <= first_data;
          out_last <= first_last;
        end
      end else if ((state == SEND) && fire) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end else begin
          out_chan <= next_idx;
          out_data <= next_data;
          out_last <= next_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Scoreboard bench for pcm_frame_sched with 16 channels: expected beats queued at launch, compared on handshake.
module tb_pcm_frame_sched;
  localparam int CH = 16;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clk_pcm = 1'b0;
  logic            overrun_clr = 1'b0;
  logic            out_ready = 1'b0;
  logic [CH*W-1:0] pcm_in = '0;
  logic [CH-1:0]   chan_mask = '0;
  logic            out_valid, out_last, overrun;
  logic [W-1:0]    out_data;
  logic [3:0]      out_chan;
  logic [7:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]   chan;
    logic [W-1:0] data;
    logic         last;
  } beat_t;
  beat_t      sb[$];
  beat_t      mon_e;
  logic [7:0] exp_fc = '0;

  always #5 clk = ~clk;

  pcm_frame_sched #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_pcm(clk_pcm), .pcm_in(pcm_in),
    .chan_mask(chan_mask), .overrun_clr(overrun_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_last(out_last), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("beat_chan", 32'(out_chan), 32'(mon_e.chan));
        check_eq("beat_data", 32'(out_data), 32'(mon_e.data));
        check_eq("beat_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  function automatic logic [CH*W-1:0] mkvec(input logic [W-1:0] d0, input logic [W-1:0] d1);
    logic [CH*W-1:0] v;
    for (int i = 0; i < CH; i++) v[i*W +: W] = 16'($urandom);
    v[0 +: W] = d0;
    v[W +: W] = d1;
    return v;
  endfunction

  task automatic push_frame(input logic [CH-1:0] m, input logic [CH*W-1:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < CH; i++) if (m[i]) hi = i;
    for (int i = 0; i < CH; i++)
      if (m[i]) sb.push_back('{chan: 4'(i), data: v[i*W +: W], last: (i == hi)});
  endtask

  // Called just after a posedge; raises clk_pcm and records the frame.
  task automatic launch(input logic [CH-1:0] m, input logic [CH*W-1:0] v, input bit accept);
    pcm_in    = v;
    chan_mask = m;
    clk_pcm   = 1'b1;
    exp_fc++;
    if (accept) push_frame(m, v);
  endtask

  task automatic pulse(input logic [CH-1:0] m, input logic [CH*W-1:0] v, input bit accept);
    launch(m, v, accept);
    repeat (3) @(posedge clk);
    #1 clk_pcm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*W-1:0] va, vb;

    // asynchronous reset, before any clock edge
    #2 reset = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_chan", 32'(out_chan), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_fc", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a frame, clk_pcm still high at release
    out_ready = 1'b0;
    va = mkvec(16'h1234, 16'hABCD);
    launch(16'h0003, va, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(out_data), 32'd0);
    check_eq("mid_rst_chan", 32'(out_chan), 32'd0);
    check_eq("mid_rst_last", 32'(out_last), 32'd0);
    check_eq("mid_rst_fc", 32'(frame_cnt), 32'd0);
    sb.delete();
    exp_fc = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("rel_no_frame_fc", 32'(frame_cnt), 32'd0);
    check_eq("rel_no_valid", 32'(out_valid), 32'd0);
    clk_pcm = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // basic drain with exact timing
    launch(16'h0003, va, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("t_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 clk_pcm = 1'b0;
    @(negedge clk);
    check_eq("t_beat0", 32'(out_valid), 32'd1);
    @(negedge clk);
    check_eq("t_beat1", 32'(out_valid), 32'd1);
    @(negedge clk);
    check_eq("t_after", 32'(out_valid), 32'd0);
    check_eq("t_fc", 32'(frame_cnt), 32'(exp_fc));
    wait_drain();

    // backpressure: 5 stalled cycles, beat 0 held stable for 6
    out_ready = 1'b0;
    launch(16'h0003, va, 1'b1);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_chan", 32'(out_chan), 32'd0);
      check_eq("bp_data", 32'(out_data), 32'h1234);
      @(posedge clk);
      #1;
      if (i == 0) clk_pcm = 1'b0;
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
    end
    wait_drain();

    // overrun: frame dropped, buffer untouched, clear, then clear colliding with a set
    out_ready = 1'b0;
    pulse(16'h0003, va, 1'b1);
    check_eq("ovr_pre", 32'(overrun), 32'd0);
    pulse(16'h0003, mkvec(16'h5555, 16'h6666), 1'b0);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    check_eq("ovr_data", 32'(out_data), 32'h1234);
    check_eq("ovr_fc", 32'(frame_cnt), 32'(exp_fc));
    overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 32'd0);
    launch(16'h0003, mkvec(16'h7777, 16'h8888), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    check_eq("ovr_set_wins", 32'(overrun), 32'd1);
    check_eq("ovr_fc2", 32'(frame_cnt), 32'(exp_fc));
    clk_pcm = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;

    // masking
    pulse(16'h0002, mkvec(16'h0BAD, 16'hBEEF), 1'b1);
    wait_drain();
    pulse(16'h0000, mkvec(16'h0101, 16'h0202), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("m0_valid", 32'(out_valid), 32'd0);
    check_eq("m0_fc", 32'(frame_cnt), 32'(exp_fc));
    pulse(16'h8001, mkvec(16'hC0DE, 16'h0F0F), 1'b1);
    wait_drain();
    pulse(16'hFFFF, mkvec(16'h1357, 16'h2468), 1'b1);
    wait_drain();

    // back-to-back: strobe lands on the final handshake
    va = mkvec(16'h1111, 16'h2222);
    vb = mkvec(16'h3333, 16'h4444);
    launch(16'h0003, va, 1'b1);
    @(posedge clk);
    #1 clk_pcm = 1'b0;
    @(posedge clk);
    #1 clk_pcm = 1'b1;
    exp_fc++;
    @(posedge clk);
    #1 pcm_in = vb;
    push_frame(16'h0003, vb);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check_eq("b2b_end", 32'(out_valid), 32'd0);
    check_eq("b2b_overrun", 32'(overrun), 32'd0);
    check_eq("b2b_fc", 32'(frame_cnt), 32'(exp_fc));
    @(posedge clk);
    #1 clk_pcm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wait_drain();

    // frame counter wrap
    while (exp_fc != 8'hFF) pulse(16'h0000, '0, 1'b1);
    check_eq("fc_255", 32'(frame_cnt), 32'hFF);
    pulse(16'h0000, '0, 1'b1);
    check_eq("fc_wrap", 32'(frame_cnt), 32'd0);
    check_eq("end_overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
